// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles the decode-stage traffic: the IF/ID inputs, the hazard-unit flush,
//   the Writeback register-write port and every registered Execute-stage output.
//   Ports (signals):
//     instrD, pcPlus4D            IF/ID register outputs
//     flushE                      bubble insert into ID/EX
//     regWriteW, rdW, resultW     Writeback register write
//     rs1D, rs2D                  combinational source indices for the hazard unit
//     *E                          registered ID/EX outputs
//   Modports:
//     slave  - the decode stage itself
//     master - whatever drives the stage (upstream pipeline or bench)
//   There is no valid/ready pair: the stage advances on every rising CLK edge,
//   and the hazard unit controls it only through flushE.
interface decode_stage_if;
    logic [31:0] instrD;
    logic [31:0] pcPlus4D;
    logic        flushE;
    logic        regWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;

    logic [4:0]  rs1D;
    logic [4:0]  rs2D;

    logic        regWriteE;
    logic        memWriteE;
    logic        jumpE;
    logic        branchE;
    logic        aluSrcE;
    logic [1:0]  resultSrcE;
    logic [2:0]  aluControlE;
    logic [31:0] rd1E;
    logic [31:0] rd2E;
    logic [31:0] pcE;
    logic [31:0] pcPlus4E;
    logic [31:0] immExtE;
    logic [4:0]  rs1E;
    logic [4:0]  rs2E;
    logic [4:0]  rdE;

    modport slave (
        input  instrD, pcPlus4D, flushE, regWriteW, rdW, resultW,
        output rs1D, rs2D,
        output regWriteE, memWriteE, jumpE, branchE, aluSrcE, resultSrcE,
        output aluControlE, rd1E, rd2E, pcE, pcPlus4E, immExtE, rs1E, rs2E, rdE
    );

    modport master (
        output instrD, pcPlus4D, flushE, regWriteW, rdW, resultW,
        input  rs1D, rs2D,
        input  regWriteE, memWriteE, jumpE, branchE, aluSrcE, resultSrcE,
        input  aluControlE, rd1E, rd2E, pcE, pcPlus4E, immExtE, rs1E, rs2E, rdE
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   RV32I instruction-decode stage: register file (2 read / 1 write), main and
//   ALU control decoders, immediate extender and the ID/EX pipeline register.
//   Ports:
//     CLK  - pipeline clock, rising edge
//     RST  - asynchronous, active-low reset (clears regfile and ID/EX)
//     bus  - decode_stage_if.slave, all data/control traffic
//   The stage has no FSM; the whole ID/EX register is visible on the bus.
module decode_stage (
    input logic           CLK,
    input logic           RST,
    decode_stage_if.slave bus
);

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [31:0] imm_ext;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } idex_t;

    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic [31:0] rd1;
    logic [31:0] rd2;

    logic        reg_write;
    logic [1:0]  imm_src;
    logic        alu_src;
    logic        mem_write;
    logic [1:0]  result_src;
    logic        branch;
    logic [1:0]  alu_op;
    logic        jump;
    logic [2:0]  alu_control;
    logic [31:0] imm_ext;

    idex_t       idex_d;
    idex_t       idex_q;

    assign op     = bus.instrD[6:0];
    assign funct3 = bus.instrD[14:12];
    assign rs1    = bus.instrD[19:15];
    assign rs2    = bus.instrD[24:20];

    assign bus.rs1D = rs1;
    assign bus.rs2D = rs2;

    // ------------------------------------------------------------------
    // Register file. regs_d is the post-write image of this cycle, so
    // reading from it gives the write-first bypass for free; x0 is never
    // written and is also forced to zero on read.
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        if (bus.regWriteW && (bus.rdW != 5'd0)) begin
            regs_d[bus.rdW] = bus.resultW;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (rs1 == 5'd0) ? 32'd0 : regs_d[rs1];
    assign rd2 = (rs2 == 5'd0) ? 32'd0 : regs_d[rs2];

    // ------------------------------------------------------------------
    // Main decoder. Unknown opcodes decode to all-zero controls, which
    // behaves as a bubble downstream.
    // ------------------------------------------------------------------
    always_comb begin
        reg_write  = 1'b0;
        imm_src    = 2'b00;
        alu_src    = 1'b0;
        mem_write  = 1'b0;
        result_src = 2'b00;
        branch     = 1'b0;
        alu_op     = 2'b00;
        jump       = 1'b0;
        case (op)
            7'b0000011: begin // lw
                reg_write  = 1'b1;
                alu_src    = 1'b1;
                result_src = 2'b01;
            end
            7'b0100011: begin // sw
                imm_src   = 2'b01;
                alu_src   = 1'b1;
                mem_write = 1'b1;
            end
            7'b0110011: begin // R-type
                reg_write = 1'b1;
                alu_op    = 2'b10;
            end
            7'b1100011: begin // beq
                imm_src = 2'b10;
                branch  = 1'b1;
                alu_op  = 2'b01;
            end
            7'b0010011: begin // I-type ALU
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_op    = 2'b10;
            end
            7'b1101111: begin // jal
                reg_write  = 1'b1;
                imm_src    = 2'b11;
                result_src = 2'b10;
                jump       = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU decoder. Subtract is only selected for R-type (op[5]=1) with
    // funct7[5] set; I-type addi with a negative immediate has bit 30 set
    // too and must still add.
    // ------------------------------------------------------------------
    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            2'b00: alu_control = 3'b000;
            2'b01: alu_control = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_control = (op[5] && bus.instrD[30]) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default: alu_control = 3'b000;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate extender.
    // ------------------------------------------------------------------
    always_comb begin
        imm_ext = 32'd0;
        case (imm_src)
            2'b00: imm_ext = {{20{bus.instrD[31]}}, bus.instrD[31:20]};
            2'b01: imm_ext = {{20{bus.instrD[31]}}, bus.instrD[31:25], bus.instrD[11:7]};
            2'b10: imm_ext = {{20{bus.instrD[31]}}, bus.instrD[7], bus.instrD[30:25],
                              bus.instrD[11:8], 1'b0};
            2'b11: imm_ext = {{12{bus.instrD[31]}}, bus.instrD[19:12], bus.instrD[20],
                              bus.instrD[30:21], 1'b0};
            default: imm_ext = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // ID/EX register. Flush wins over capture and zeroes every field.
    // ------------------------------------------------------------------
    always_comb begin
        idex_d = '0;
        if (!bus.flushE) begin
            idex_d.reg_write   = reg_write;
            idex_d.mem_write   = mem_write;
            idex_d.jump        = jump;
            idex_d.branch      = branch;
            idex_d.alu_src     = alu_src;
            idex_d.result_src  = result_src;
            idex_d.alu_control = alu_control;
            idex_d.rd1         = rd1;
            idex_d.rd2         = rd2;
            idex_d.pc          = bus.pcPlus4D - 32'd4;
            idex_d.pc_plus4    = bus.pcPlus4D;
            idex_d.imm_ext     = imm_ext;
            idex_d.rs1         = rs1;
            idex_d.rs2         = rs2;
            idex_d.rd          = bus.instrD[11:7];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.regWriteE   = idex_q.reg_write;
    assign bus.memWriteE   = idex_q.mem_write;
    assign bus.jumpE       = idex_q.jump;
    assign bus.branchE     = idex_q.branch;
    assign bus.aluSrcE     = idex_q.alu_src;
    assign bus.resultSrcE  = idex_q.result_src;
    assign bus.aluControlE = idex_q.alu_control;
    assign bus.rd1E        = idex_q.rd1;
    assign bus.rd2E        = idex_q.rd2;
    assign bus.pcE         = idex_q.pc;
    assign bus.pcPlus4E    = idex_q.pc_plus4;
    assign bus.immExtE     = idex_q.imm_ext;
    assign bus.rs1E        = idex_q.rs1;
    assign bus.rs2E        = idex_q.rs2;
    assign bus.rdE         = idex_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Directed vectors for decode_stage. Each issued vector pushes its
//   hand-computed ID/EX image onto exp_q; an independent monitor pops and
//   compares one entry after every rising edge while entries are pending.
//   Expected image layout: {regWrite, memWrite, jump, branch, aluSrc,
//   resultSrc[1:0], aluControl[2:0], rd1, rd2, pc, pcPlus4, immExt, rs1, rs2, rd}.
module tb_decode_stage;

    localparam int EW = 185;

    logic CLK;
    logic RST;

    decode_stage_if bus ();

    decode_stage dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks;
    int            fails;

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] actual_image();
        return {bus.regWriteE, bus.memWriteE, bus.jumpE, bus.branchE, bus.aluSrcE,
                bus.resultSrcE, bus.aluControlE, bus.rd1E, bus.rd2E, bus.pcE,
                bus.pcPlus4E, bus.immExtE, bus.rs1E, bus.rs2E, bus.rdE};
    endfunction

    function automatic logic [EW-1:0] mk(input logic [9:0] ctl, input logic [31:0] rd1,
                                         input logic [31:0] rd2, input logic [31:0] pc,
                                         input logic [31:0] pc4, input logic [31:0] imm,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [4:0] rd);
        return {ctl, rd1, rd2, pc, pc4, imm, rs1, rs2, rd};
    endfunction

    task automatic chk(input string nm, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input string nm, input logic [31:0] instr, input logic [31:0] pc4,
                         input logic flush, input logic wr, input logic [4:0] rdw,
                         input logic [31:0] resw, input logic [EW-1:0] exp);
        @(negedge CLK);
        bus.instrD    = instr;
        bus.pcPlus4D  = pc4;
        bus.flushE    = flush;
        bus.regWriteW = wr;
        bus.rdW       = rdw;
        bus.resultW   = resw;
        exp_q.push_back(exp);
        name_q.push_back(nm);
        #1;
        chk({nm, "_rsD"}, EW'({bus.rs1D, bus.rs2D}), EW'({instr[19:15], instr[24:20]}));
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge CLK);
        if (exp_q.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [EW-1:0] e;
        string         n;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                chk(n, actual_image(), e);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks        = 0;
        fails         = 0;
        RST           = 1'b1;
        bus.instrD    = 32'h0;
        bus.pcPlus4D  = 32'h0;
        bus.flushE    = 1'b0;
        bus.regWriteW = 1'b0;
        bus.rdW       = 5'd0;
        bus.resultW   = 32'h0;
        #2 RST = 1'b0;
        #1 chk("reset_outputs", actual_image(), '0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;

        // addi x5, x0, 10
        issue("addi", 32'h00A00293, 32'h104, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_1_00_000, 32'h0, 32'h0, 32'h100, 32'h104, 32'hA, 5'd0, 5'd10, 5'd5));
        // lw x6, 8(x5) while Writeback writes x5 = 0x1234 (bypass on port 1)
        issue("lw_bypass", 32'h0082A303, 32'h108, 0, 1, 5'd5, 32'h1234,
              mk(10'b1_0_0_0_1_01_000, 32'h1234, 32'h0, 32'h104, 32'h108, 32'h8, 5'd5, 5'd8, 5'd6));
        // add x7, x0, x5 while Writeback targets x0 (must be ignored)
        issue("add_x0_write", 32'h005003B3, 32'h10C, 0, 1, 5'd0, 32'hDEAD,
              mk(10'b1_0_0_0_0_00_000, 32'h0, 32'h1234, 32'h108, 32'h10C, 32'h5, 5'd0, 5'd5, 5'd7));
        // add x5, x0, x0: x0 still reads 0; write x1 in the background
        issue("read_x0", 32'h000002B3, 32'h110, 0, 1, 5'd1, 32'h11111111,
              mk(10'b1_0_0_0_0_00_000, 32'h0, 32'h0, 32'h10C, 32'h110, 32'h0, 5'd0, 5'd0, 5'd5));
        // beq x1, x2, -4 while Writeback writes x2 (bypass on port 2)
        issue("beq", 32'hFE208EE3, 32'h114, 0, 1, 5'd2, 32'h22222222,
              mk(10'b0_0_0_1_0_00_001, 32'h11111111, 32'h22222222, 32'h110, 32'h114,
                 32'hFFFFFFFC, 5'd1, 5'd2, 5'd29));
        // flushed addi, then normal capture resumes
        issue("flush", 32'h00A00293, 32'h104, 1, 0, 5'd0, 32'h0, '0);
        issue("after_flush", 32'h00A00293, 32'h104, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_1_00_000, 32'h0, 32'h0, 32'h100, 32'h104, 32'hA, 5'd0, 5'd10, 5'd5));
        // unknown opcode: all controls zero
        issue("unknown_op", 32'h0000007F, 32'h200, 0, 0, 5'd0, 32'h0,
              mk(10'b0, 32'h0, 32'h0, 32'h1FC, 32'h200, 32'h0, 5'd0, 5'd0, 5'd0));
        // sub x0, x1, x2
        issue("sub", 32'h40208033, 32'h204, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_0_00_001, 32'h11111111, 32'h22222222, 32'h200, 32'h204,
                 32'h402, 5'd1, 5'd2, 5'd0));
        // jal x1, 8
        issue("jal", 32'h008000EF, 32'h300, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_1_0_0_10_000, 32'h0, 32'h0, 32'h2FC, 32'h300, 32'h8, 5'd0, 5'd8, 5'd1));
        // sw x2, 12(x1)
        issue("sw", 32'h0020A623, 32'h304, 0, 0, 5'd0, 32'h0,
              mk(10'b0_1_0_0_1_00_000, 32'h11111111, 32'h22222222, 32'h300, 32'h304,
                 32'hC, 5'd1, 5'd2, 5'd12));
        // or x3, x1, x2
        issue("or", 32'h0020E1B3, 32'h308, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_0_00_011, 32'h11111111, 32'h22222222, 32'h304, 32'h308,
                 32'h2, 5'd1, 5'd2, 5'd3));
        // slti x4, x1, -1 with pcPlus4D = 0 (pc wraps)
        issue("slti_pcwrap", 32'hFFF0A213, 32'h0, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_1_00_101, 32'h11111111, 32'h0, 32'hFFFFFFFC, 32'h0,
                 32'hFFFFFFFF, 5'd1, 5'd31, 5'd4));
        // andi x4, x1, 15
        issue("andi", 32'h00F0F213, 32'h404, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_1_00_010, 32'h11111111, 32'h0, 32'h400, 32'h404,
                 32'hF, 5'd1, 5'd15, 5'd4));
        // xori x4, x1, 1: unhandled funct3 falls back to add
        issue("xori", 32'h0010C213, 32'h408, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_1_00_000, 32'h11111111, 32'h11111111, 32'h404, 32'h408,
                 32'h1, 5'd1, 5'd1, 5'd4));
        drain();

        // Reset asserted mid-instruction: outputs clear before the next edge.
        @(negedge CLK);
        bus.instrD   = 32'h00A00293;
        bus.pcPlus4D = 32'h104;
        #2 RST = 1'b0;
        #1 chk("reset_mid", actual_image(), '0);
        @(negedge CLK);
        RST = 1'b1;

        // lw x6, 8(x5): x5 was cleared by reset
        issue("x5_after_reset", 32'h0082A303, 32'h108, 0, 0, 5'd0, 32'h0,
              mk(10'b1_0_0_0_1_01_000, 32'h0, 32'h0, 32'h104, 32'h108, 32'h8, 5'd5, 5'd8, 5'd6));
        drain();

        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
